// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 scan-code decoder: prefix bytes, handshake
// state encoding and the "no character" ASCII value.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] POP   = 1'b1;

    localparam logic [7:0] NUL = 8'h00;

endpackage

// File: rtl/ps2_ascii_rom.sv
// Combinational scan-code set 2 to ASCII table; extended codes and anything
// outside letters, digit row and space map to NUL.
module ps2_ascii_rom
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = NUL;
        if (!ext) begin
            case (code)
                8'h1C: ascii = 8'h61; // a
                8'h32: ascii = 8'h62;
                8'h21: ascii = 8'h63;
                8'h23: ascii = 8'h64;
                8'h24: ascii = 8'h65;
                8'h2B: ascii = 8'h66;
                8'h34: ascii = 8'h67;
                8'h33: ascii = 8'h68;
                8'h43: ascii = 8'h69;
                8'h3B: ascii = 8'h6A;
                8'h42: ascii = 8'h6B;
                8'h4B: ascii = 8'h6C;
                8'h3A: ascii = 8'h6D;
                8'h31: ascii = 8'h6E;
                8'h44: ascii = 8'h6F;
                8'h4D: ascii = 8'h70;
                8'h15: ascii = 8'h71;
                8'h2D: ascii = 8'h72;
                8'h1B: ascii = 8'h73;
                8'h2C: ascii = 8'h74;
                8'h3C: ascii = 8'h75;
                8'h2A: ascii = 8'h76;
                8'h1D: ascii = 8'h77;
                8'h22: ascii = 8'h78;
                8'h35: ascii = 8'h79;
                8'h1A: ascii = 8'h7A; // z
                8'h45: ascii = 8'h30; // 0
                8'h16: ascii = 8'h31;
                8'h1E: ascii = 8'h32;
                8'h26: ascii = 8'h33;
                8'h25: ascii = 8'h34;
                8'h2E: ascii = 8'h35;
                8'h36: ascii = 8'h36;
                8'h3D: ascii = 8'h37;
                8'h3E: ascii = 8'h38;
                8'h46: ascii = 8'h39; // 9
                8'h29: ascii = 8'h20; // space
                default: ascii = NUL;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Pops bytes from the PS/2 controller FIFO, decodes E0/F0 prefixes and tracks
// the currently held key, its ASCII value and a press counter.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ready,
    input  logic [7:0]       data,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic [7:0]       scan_code,
    output logic             extended,
    output logic [7:0]       ascii,
    output logic [CNT_W-1:0] cnt
);

    logic [0:0]       r_state;
    logic             r_nextdata_n;
    logic             r_key_valid;
    logic [7:0]       r_scan_code;
    logic             r_extended;
    logic [7:0]       r_ascii;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ext_pend;
    logic             r_brk_pend;

    logic [7:0] w_ascii;
    logic       w_same_key;

    ps2_ascii_rom u_ascii_rom (
        .code  (data),
        .ext   (r_ext_pend),
        .ascii (w_ascii)
    );

    // Byte refers to the key already held (release target or typematic repeat)
    assign w_same_key = r_key_valid && ({r_ext_pend, data} == {r_extended, r_scan_code});

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state      <= FETCH;
            r_nextdata_n <= 1'b1;
            r_key_valid  <= 1'b0;
            r_scan_code  <= 8'h00;
            r_extended   <= 1'b0;
            r_ascii      <= NUL;
            r_cnt        <= '0;
            r_ext_pend   <= 1'b0;
            r_brk_pend   <= 1'b0;
        end else if (r_state == POP) begin
            // FIFO pointer advances on this edge, so ready is not looked at
            r_nextdata_n <= 1'b1;
            r_state      <= FETCH;
        end else if (ready) begin
            r_nextdata_n <= 1'b0;
            r_state      <= POP;
            if (data == PS2_EXT) begin
                r_ext_pend <= 1'b1;
            end else if (data == PS2_BRK) begin
                r_brk_pend <= 1'b1;
            end else if (r_brk_pend) begin
                if (w_same_key) begin
                    r_key_valid <= 1'b0;
                end
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end else if (w_same_key) begin
                r_ext_pend <= 1'b0;
            end else begin
                r_scan_code <= data;
                r_extended  <= r_ext_pend;
                r_ascii     <= w_ascii;
                r_key_valid <= 1'b1;
                r_cnt       <= r_cnt + 1'b1;
                r_ext_pend  <= 1'b0;
            end
        end
    end

    assign nextdata_n = r_nextdata_n;
    assign key_valid  = r_key_valid;
    assign scan_code  = r_scan_code;
    assign extended   = r_extended;
    assign ascii      = r_ascii;
    assign cnt        = r_cnt;

endmodule
